// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: ALU opcodes, exception causes, mem_flags layout and FSM states for the execute stage
package ex_stage_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;
   localparam logic [3:0] CAUSE_ADDR    = 4'd0;
   localparam logic [3:0] CAUSE_BREAK   = 4'd3;
   localparam logic [3:0] CAUSE_SYSCALL = 4'd11;
   localparam int MF_LOAD     = 0;
   localparam int MF_STORE    = 1;
   localparam int MF_BYTE     = 2;
   localparam int MF_HALF     = 3;
   localparam int MF_WORD     = 4;
   localparam int MF_UNSIGNED = 5;
   typedef enum logic {RUN = 1'b0, TRAP_WAIT = 1'b1} state_e;
endpackage

// File: rtl/ex_stage_alu.sv
// ex_stage_alu: combinational integer ALU; undefined opcodes yield zero
module ex_stage_alu import ex_stage_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   output logic [XLEN-1:0] result
);
   localparam int SW = $clog2(XLEN);
   logic [SW-1:0] sh;
   assign sh = b[SW-1:0];
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << sh;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> sh;
         ALU_SRA:  result = $unsigned($signed(a) >>> sh);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = '0;
      endcase
   end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with EX/MEM register, decode forwarding, exception cause
// priority and a trap-wait FSM that squashes younger instructions until the trap is taken
module ex_stage import ex_stage_pkg::*; #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ex_ready,
   input  logic [XLEN-1:0] ex_port_a,
   input  logic [XLEN-1:0] ex_port_b,
   input  logic [3:0]      ex_alu_op,
   input  logic [XLEN-1:0] ex_store_data,
   input  logic [4:0]      ex_waddr,
   input  logic            ex_we,
   input  logic [5:0]      ex_mem_flags,
   input  logic            ex_mem_ex_sel,
   input  logic            ex_exc_addr_if,
   input  logic            ex_bad_jump_addr,
   input  logic            ex_bad_branch_addr,
   input  logic            ex_syscall_op,
   input  logic            ex_break_op,
   input  logic            mem_stall,
   input  logic            flush_i,
   input  logic            trap_ack_i,
   output logic            ex_stall_o,
   output logic [XLEN-1:0] fwd_data,
   output logic [4:0]      fwd_addr,
   output logic            fwd_we,
   output logic            mem_valid,
   output logic [XLEN-1:0] mem_alu_result,
   output logic [XLEN-1:0] mem_store_data,
   output logic [4:0]      mem_waddr,
   output logic            mem_we,
   output logic [5:0]      mem_mem_flags,
   output logic            mem_mem_ex_sel,
   output logic            mem_exc_valid,
   output logic [3:0]      mem_exc_cause
);
   logic [XLEN-1:0] alu_result;
   logic            addr_exc;
   logic            exc;
   logic [3:0]      cause;
   logic            live;
   logic            clean;
   logic            load;
   state_e          state;
   ex_stage_alu #(.XLEN(XLEN)) u_alu (.a(ex_port_a), .b(ex_port_b), .op(ex_alu_op), .result(alu_result));
   assign addr_exc = ex_exc_addr_if | ex_bad_jump_addr | ex_bad_branch_addr;
   assign exc      = addr_exc | ex_syscall_op | ex_break_op;
   assign cause    = addr_exc ? CAUSE_ADDR : ex_syscall_op ? CAUSE_SYSCALL : ex_break_op ? CAUSE_BREAK : CAUSE_ADDR;
   // an acknowledge releases the squash for the instruction loading in the same cycle
   assign live     = ex_ready & ((state == RUN) | trap_ack_i);
   assign clean    = live & ~exc;
   assign load     = ~flush_i & ~mem_stall;
   assign ex_stall_o = mem_stall;
   assign fwd_data   = alu_result;
   assign fwd_addr   = ex_waddr;
   assign fwd_we     = ex_ready & ex_we & (|ex_waddr) & ~exc & (state == RUN);
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state          <= RUN;
         mem_valid      <= 1'b0;
         mem_alu_result <= RESET_VEC;
         mem_store_data <= '0;
         mem_waddr      <= '0;
         mem_we         <= 1'b0;
         mem_mem_flags  <= '0;
         mem_mem_ex_sel <= 1'b0;
         mem_exc_valid  <= 1'b0;
         mem_exc_cause  <= '0;
      end else begin
         if (flush_i) begin
            mem_valid     <= 1'b0;
            mem_we        <= 1'b0;
            mem_mem_flags <= '0;
            mem_exc_valid <= 1'b0;
         end else if (load) begin
            mem_valid      <= live;
            mem_alu_result <= alu_result;
            mem_store_data <= ex_store_data;
            mem_waddr      <= ex_waddr;
            mem_we         <= clean & ex_we & (|ex_waddr);
            mem_mem_flags  <= clean ? ex_mem_flags : '0;
            mem_mem_ex_sel <= ex_mem_ex_sel;
            mem_exc_valid  <= live & exc;
            mem_exc_cause  <= cause;
         end
         state <= (load & live & exc) ? TRAP_WAIT : trap_ack_i ? RUN : state;
      end
   end
endmodule
